// File: rtl/green_draw_pkg.sv
// Shared encodings and window register layout for the multi-rectangle green overlay.
// Coordinates are stored zero-extended to COORD_W, so the top supports XW and YW up to 16.
package green_draw_pkg;

  localparam int COORD_W = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    FLD_X1   = 3'd0,
    FLD_X2   = 3'd1,
    FLD_Y1   = 3'd2,
    FLD_Y2   = 3'd3,
    FLD_CTRL = 3'd4
  } cfg_field_e;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_BORDER_BIT = 1;
  localparam int CTRL_BLINK_BIT  = 2;

  typedef struct packed {
    coord_t x1;
    coord_t x2;
    coord_t y1;
    coord_t y2;
    logic   en;
    logic   border;
    logic   blink;
  } win_cfg_t;

  function automatic win_cfg_t write_field(input win_cfg_t   cur,
                                           input logic [2:0] fld,
                                           input coord_t     x_data,
                                           input coord_t     y_data,
                                           input logic [2:0] ctrl);
    win_cfg_t nxt;
    nxt = cur;
    case (fld)
      FLD_X1:   nxt.x1 = x_data;
      FLD_X2:   nxt.x2 = x_data;
      FLD_Y1:   nxt.y1 = y_data;
      FLD_Y2:   nxt.y2 = y_data;
      FLD_CTRL: begin
        nxt.en     = ctrl[CTRL_EN_BIT];
        nxt.border = ctrl[CTRL_BORDER_BIT];
        nxt.blink  = ctrl[CTRL_BLINK_BIT];
      end
      default:  nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/green_win_cmp.sv
// Combinational hit test of one pixel against one rectangle, filled or border-only.
module green_win_cmp
  import green_draw_pkg::*;
#(
  parameter int BORDER_W = 2
) (
  input  win_cfg_t cfg_i,
  input  logic     en_i,
  input  coord_t   x_i,
  input  coord_t   y_i,
  input  logic     blink_phase_i,
  output logic     hit_o
);

  localparam int SW = COORD_W + 1;

  // One extra bit keeps the border sums from wrapping near the coordinate limit.
  logic [SW-1:0] bw;
  logic [SW-1:0] x_w;
  logic [SW-1:0] y_w;
  logic          in_x;
  logic          in_y;
  logic          on_edge;
  logic          masked;

  assign bw  = SW'(BORDER_W);
  assign x_w = SW'(x_i);
  assign y_w = SW'(y_i);

  assign in_x = (cfg_i.x1 <= x_i) && (x_i <= cfg_i.x2);
  assign in_y = (cfg_i.y1 <= y_i) && (y_i <= cfg_i.y2);

  assign on_edge = (x_w < (SW'(cfg_i.x1) + bw)) ||
                   ((x_w + bw) > SW'(cfg_i.x2)) ||
                   (y_w < (SW'(cfg_i.y1) + bw)) ||
                   ((y_w + bw) > SW'(cfg_i.y2));

  assign masked = cfg_i.blink & blink_phase_i;

  assign hit_o = en_i & cfg_i.en & in_x & in_y & (~cfg_i.border | on_edge) & ~masked;

endmodule

// File: rtl/green_draw_multi.sv
// Green overlay for N_WIN double-buffered rectangles, two-stage pipeline to outg/hit flags.
// Optional blink masking is built when GREEN_DRAW_BLINK_EN is defined.
module green_draw_multi
  import green_draw_pkg::*;
#(
  parameter int N_WIN      = 4,
  parameter int XW         = 11,
  parameter int YW         = 10,
  parameter int BORDER_W   = 2,
  parameter int BLINK_LOG2 = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [XW-1:0]    gr_x,
  input  logic [YW-1:0]    gr_y,
  input  logic             frame_start,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_idx,
  input  logic [2:0]       cfg_field,
  input  logic [XW-1:0]    cfg_data,
  output logic             outg,
  output logic [N_WIN-1:0] hit_vec,
  output logic [3:0]       hit_idx,
  output logic             hit_valid
);

  win_cfg_t shadow_q [N_WIN];
  win_cfg_t shadow_d [N_WIN];
  win_cfg_t active_q [N_WIN];
  win_cfg_t active_d [N_WIN];

  logic             wr_ok;
  coord_t           x_data;
  coord_t           y_data;
  logic             blink_phase;
  logic [N_WIN-1:0] hit_comb;

  logic [N_WIN-1:0] hit_s1_q, hit_s1_d;
  logic [N_WIN-1:0] hit_vec_q, hit_vec_d;
  logic             outg_q, outg_d;
  logic [3:0]       hit_idx_q, hit_idx_d;

  assign wr_ok  = cfg_we && (32'(cfg_idx) < 32'(N_WIN)) && (cfg_field <= FLD_CTRL);
  assign x_data = coord_t'(cfg_data);
  assign y_data = coord_t'(cfg_data[YW-1:0]);

  // Commit reads shadow_q, so a same-cycle write is picked up on the following frame_start.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (frame_start) begin
      active_d = shadow_q;
    end
    if (wr_ok) begin
      for (int w = 0; w < N_WIN; w++) begin
        if (cfg_idx == 4'(w)) begin
          shadow_d[w] = write_field(shadow_q[w], cfg_field, x_data, y_data, cfg_data[2:0]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

`ifdef GREEN_DRAW_BLINK_EN
  logic [BLINK_LOG2-1:0] blink_cnt_q, blink_cnt_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    if (frame_start) begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign blink_phase = blink_cnt_q[BLINK_LOG2-1];
`else
  assign blink_phase = 1'b0;
`endif

  for (genvar w = 0; w < N_WIN; w++) begin : g_win
    green_win_cmp #(
      .BORDER_W (BORDER_W)
    ) u_cmp (
      .cfg_i         (active_q[w]),
      .en_i          (en),
      .x_i           (coord_t'(gr_x)),
      .y_i           (coord_t'(gr_y)),
      .blink_phase_i (blink_phase),
      .hit_o         (hit_comb[w])
    );
  end

  // Lowest index wins: scan downward so the last assignment is the smallest hit.
  always_comb begin
    hit_s1_d  = hit_comb;
    hit_vec_d = hit_s1_q;
    outg_d    = |hit_s1_q;
    hit_idx_d = 4'd0;
    for (int w = N_WIN - 1; w >= 0; w--) begin
      if (hit_s1_q[w]) begin
        hit_idx_d = 4'(w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_s1_q  <= '0;
      hit_vec_q <= '0;
      outg_q    <= 1'b0;
      hit_idx_q <= 4'd0;
    end else begin
      hit_s1_q  <= hit_s1_d;
      hit_vec_q <= hit_vec_d;
      outg_q    <= outg_d;
      hit_idx_q <= hit_idx_d;
    end
  end

  assign outg      = outg_q;
  assign hit_vec   = hit_vec_q;
  assign hit_idx   = hit_idx_q;
  assign hit_valid = |hit_vec_q;

endmodule
